// File: rtl/pwm_encoder_pkg.sv
// Shared types and defaults for the PWM frame encoder.
package pwm_encoder_pkg;
   localparam int VAL_BITS_DEF = 4;
   localparam int N_CH_DEF     = 8;
   localparam int ADDR_W       = 3;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/pwm_frame_counter.sv
// Frame position counter: counts up while enabled, clear wins, tc flags the last slot.
module pwm_frame_counter #(
   parameter int VAL_BITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                en,
   output logic [VAL_BITS-1:0] cnt,
   output logic                tc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == {VAL_BITS{1'b1}});

endmodule

// File: rtl/pwm_encoder.sv
// Multi-channel PWM encoder: each channel's falling edge encodes its value within a frame.
// Optional PWM_ENCODER_SHADOW_EN adds a shadow value bank that is loaded into use at frame start.
//
// state | meaning
// IDLE  | waiting for i_start, value writes accepted
// RUN   | frame in progress, channels fall when cnt matches their value
module pwm_encoder
   import pwm_encoder_pkg::*;
#(
   parameter int VAL_BITS = VAL_BITS_DEF,
   parameter int N_CH     = N_CH_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_wr,
   input  logic [ADDR_W-1:0]   i_addr,
   input  logic [VAL_BITS-1:0] i_wdata,
   input  logic                i_start,
   output logic [N_CH-1:0]     o_pwm,
   output logic [N_CH-1:0]     o_fall,
   output logic                o_busy,
   output logic                o_done
);

   state_t              state;
   logic [VAL_BITS-1:0] val_q   [N_CH];
   logic [VAL_BITS-1:0] val_nxt [N_CH];
   logic [VAL_BITS-1:0] cnt;
   logic                tc;
   logic                start_ok;
   logic                cnt_clr;
   logic                cnt_en;

   // A start seen while the done strobe is out is dropped so frames never run back-to-back.
   assign start_ok = (state == IDLE) && i_start && !o_done;
   assign cnt_clr  = (state == RUN) && tc;
   assign cnt_en   = start_ok || (state == RUN);

   pwm_frame_counter #(
      .VAL_BITS (VAL_BITS)
   ) u_frame_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .cnt   (cnt),
      .tc    (tc)
   );

`ifdef PWM_ENCODER_SHADOW_EN
   logic [VAL_BITS-1:0] shd_q   [N_CH];
   logic [VAL_BITS-1:0] shd_nxt [N_CH];

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         shd_nxt[i] = shd_q[i];
         if (i_wr && (i_addr == ADDR_W'(i))) begin
            shd_nxt[i] = i_wdata;
         end
         val_nxt[i] = start_ok ? shd_nxt[i] : val_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            shd_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            shd_q[i] <= shd_nxt[i];
         end
      end
   end
`else
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         val_nxt[i] = val_q[i];
         if ((state == IDLE) && i_wr && (i_addr == ADDR_W'(i))) begin
            val_nxt[i] = i_wdata;
         end
      end
   end
`endif

   // Start uses val_nxt so a write landing on the start edge is part of the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         o_pwm  <= '0;
         o_fall <= '0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            val_q[i] <= '0;
         end
      end else begin
         o_fall <= '0;
         o_done <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            val_q[i] <= val_nxt[i];
         end
         case (state)
            IDLE: begin
               if (start_ok) begin
                  state  <= RUN;
                  o_busy <= 1'b1;
                  for (int i = 0; i < N_CH; i++) begin
                     o_pwm[i] <= (val_nxt[i] != '0);
                  end
               end
            end
            RUN: begin
               for (int i = 0; i < N_CH; i++) begin
                  if (o_pwm[i] && (cnt == val_q[i])) begin
                     o_pwm[i]  <= 1'b0;
                     o_fall[i] <= 1'b1;
                  end
               end
               if (tc) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
